// File: rtl/core_lsu_pkg.sv
// Shared types and lane helpers for the load/store unit.
// Contents: size encodings, FSM state encoding, captured-request payload,
// byte-enable generation, store-data replication and load extraction.
package core_lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Fields kept from the accepted request that the load path needs later.
  typedef struct packed {
    lsu_size_e  size;
    logic       uns;
    logic [1:0] lane;
  } lsu_req_t;

  // Byte enables for a store; half ignores lane[0], word/reserved take all lanes.
  function automatic logic [BE_W-1:0] be_gen(input lsu_size_e sz, input logic [1:0] lane);
    logic [BE_W-1:0] be;
    case (sz)
      SZ_B:    be = BE_W'(4'b0001 << lane);
      SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'hF;
    endcase
    return be;
  endfunction

  // Replicate store data across every lane it could land in.
  function automatic logic [XLEN-1:0] wdata_rep(input lsu_size_e sz, input logic [XLEN-1:0] w);
    logic [XLEN-1:0] r;
    case (sz)
      SZ_B:    r = {4{w[7:0]}};
      SZ_H:    r = {2{w[15:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

  // Pull the addressed byte/half out of the loaded word and extend it.
  function automatic logic [XLEN-1:0] load_extend(input lsu_size_e sz, input logic [1:0] lane,
                                                  input logic uns, input logic [XLEN-1:0] w);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (sz)
      SZ_B:    r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/core_lsu_if.sv
// Data-memory port bundle: valid/ready request channel plus rvalid response.
// master = LSU side, slave = memory side.
interface core_lsu_if;
  import core_lsu_pkg::*;

  logic                DMEM_VALID;
  logic                DMEM_READY;
  logic [XLEN-1:0]     DMEM_ADDR;
  logic                DMEM_WE;
  logic [BE_W-1:0]     DMEM_BE;
  logic [XLEN-1:0]     DMEM_WDATA;
  logic                DMEM_RVALID;
  logic [XLEN-1:0]     DMEM_RDATA;

  modport master (
    output DMEM_VALID, DMEM_ADDR, DMEM_WE, DMEM_BE, DMEM_WDATA,
    input  DMEM_READY, DMEM_RVALID, DMEM_RDATA
  );

  modport slave (
    input  DMEM_VALID, DMEM_ADDR, DMEM_WE, DMEM_BE, DMEM_WDATA,
    output DMEM_READY, DMEM_RVALID, DMEM_RDATA
  );
endinterface

// File: rtl/core_lsu_align.sv
// Combinational lane steering for the LSU.
// Store side: st_size_i/st_lane_i/st_wdata_i -> be_o, wdata_o.
// Load side:  ld_size_i/ld_lane_i/ld_unsigned_i/ld_rdata_i -> ld_data_o.
module core_lsu_align
  import core_lsu_pkg::*;
(
  input  lsu_size_e       st_size_i,
  input  logic [1:0]      st_lane_i,
  input  logic [XLEN-1:0] st_wdata_i,
  input  lsu_size_e       ld_size_i,
  input  logic [1:0]      ld_lane_i,
  input  logic            ld_unsigned_i,
  input  logic [XLEN-1:0] ld_rdata_i,
  output logic [BE_W-1:0] be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] ld_data_o
);

  assign be_o      = be_gen(st_size_i, st_lane_i);
  assign wdata_o   = wdata_rep(st_size_i, st_wdata_i);
  assign ld_data_o = load_extend(ld_size_i, ld_lane_i, ld_unsigned_i, ld_rdata_i);

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: turns one core request into a word-aligned memory
// transaction and returns extended load data with a one-cycle done pulse.
// Core side: CLK, RST_N (sync, active-low), LSU_REQ/WE/SIZE/UNSIGNED/ADDR/WDATA
// in; LSU_BUSY/DONE/ERR/RDATA out. Memory side: dmem (core_lsu_if.master).
// Optional macro CORE_LSU_MISALIGN_TRAP_EN: misaligned half/word and reserved
// size complete immediately with LSU_ERR and issue no memory request.
module core_lsu
  import core_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            LSU_REQ,
  input  logic            LSU_WE,
  input  logic [1:0]      LSU_SIZE,
  input  logic            LSU_UNSIGNED,
  input  logic [XLEN-1:0] LSU_ADDR,
  input  logic [XLEN-1:0] LSU_WDATA,
  output logic            LSU_BUSY,
  output logic            LSU_DONE,
  output logic            LSU_ERR,
  output logic [XLEN-1:0] LSU_RDATA,
  core_lsu_if.master      dmem
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  lsu_state_e      state_q, state_d;
  lsu_req_t        req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            valid_q, valid_d, we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [BE_W-1:0] be_q, be_d;

  lsu_size_e       size_c;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] wdata_c, ld_data_c;
  logic            misalign_c, timeout_c;

  assign size_c = lsu_size_e'(LSU_SIZE);

  core_lsu_align u_align (
    .st_size_i     (size_c),
    .st_lane_i     (LSU_ADDR[1:0]),
    .st_wdata_i    (LSU_WDATA),
    .ld_size_i     (req_q.size),
    .ld_lane_i     (req_q.lane),
    .ld_unsigned_i (req_q.uns),
    .ld_rdata_i    (dmem.DMEM_RDATA),
    .be_o          (be_c),
    .wdata_o       (wdata_c),
    .ld_data_o     (ld_data_c)
  );

`ifdef CORE_LSU_MISALIGN_TRAP_EN
  assign misalign_c = ((size_c == SZ_H) && LSU_ADDR[0]) ||
                      ((size_c == SZ_W) && (LSU_ADDR[1:0] != 2'b00)) ||
                      (size_c == SZ_RSV);
`else
  assign misalign_c = 1'b0;
`endif

  // Counter value cnt_q == N means this is the (N+1)th cycle in REQ+RESP.
  assign timeout_c = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (LSU_REQ) begin
          req_d   = '{size: size_c, uns: LSU_UNSIGNED, lane: LSU_ADDR[1:0]};
          addr_d  = {LSU_ADDR[XLEN-1:2], 2'b00};
          we_d    = LSU_WE;
          be_d    = LSU_WE ? be_c : 4'hF;
          wdata_d = wdata_c;
          cnt_d   = '0;
          if (misalign_c) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ST_REQ;
            valid_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        cnt_d   = cnt_q + CNT_W'(1);
        valid_d = 1'b1;
        // A handshake in the last allowed cycle still completes normally.
        if (dmem.DMEM_READY) begin
          valid_d = 1'b0;
          if (we_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ST_RESP;
          end
        end else if (timeout_c) begin
          valid_d = 1'b0;
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      ST_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem.DMEM_RVALID) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          rdata_d = ld_data_c;
        end else if (timeout_c) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign LSU_BUSY        = busy_q;
  assign LSU_DONE        = done_q;
  assign LSU_ERR         = err_q;
  assign LSU_RDATA       = rdata_q;
  assign dmem.DMEM_VALID = valid_q;
  assign dmem.DMEM_ADDR  = addr_q;
  assign dmem.DMEM_WE    = we_q;
  assign dmem.DMEM_BE    = be_q;
  assign dmem.DMEM_WDATA = wdata_q;

endmodule

// File: tb/tb_core_lsu.sv
// Self-checking bench for core_lsu: table of directed transactions against a
// responsive memory stub, plus timeout and mid-transaction reset sequences.
module tb_core_lsu;

  logic        CLK;
  logic        RST_N;
  logic        LSU_REQ, LSU_WE, LSU_UNSIGNED;
  logic [1:0]  LSU_SIZE;
  logic [31:0] LSU_ADDR, LSU_WDATA;
  logic        LSU_BUSY, LSU_DONE, LSU_ERR;
  logic [31:0] LSU_RDATA;

  core_lsu_if dmem ();

  core_lsu #(.TIMEOUT_CYC(8)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .LSU_REQ      (LSU_REQ),
    .LSU_WE       (LSU_WE),
    .LSU_SIZE     (LSU_SIZE),
    .LSU_UNSIGNED (LSU_UNSIGNED),
    .LSU_ADDR     (LSU_ADDR),
    .LSU_WDATA    (LSU_WDATA),
    .LSU_BUSY     (LSU_BUSY),
    .LSU_DONE     (LSU_DONE),
    .LSU_ERR      (LSU_ERR),
    .LSU_RDATA    (LSU_RDATA),
    .dmem         (dmem)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          rdy_dly;
    int          rv_dly;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int rdy_dly, input int rv_dly,
                              input logic exp_req, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.rdy_dly = rdy_dly; v.rv_dly = rv_dly; v.exp_req = exp_req; v.exp_addr = exp_addr;
    v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata;
    v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  // Issue one request and act as memory; checks latency, bus fields and result.
  task automatic run_vec(input vec_t v, input int idx);
    int          cyc, vcnt, hs_cyc, lat;
    logic        got_done, err, busy, we_seen;
    logic [31:0] a, wd, rd;
    logic [3:0]  be;
    string       tag;
    @(posedge CLK); #1;
    LSU_REQ = 1'b1; LSU_WE = v.we; LSU_SIZE = v.size; LSU_UNSIGNED = v.uns;
    LSU_ADDR = v.addr; LSU_WDATA = v.wdata; dmem.DMEM_RDATA = v.rdata;
    cyc = 0; vcnt = 0; hs_cyc = -1; lat = -1; got_done = 1'b0;
    a = '0; wd = '0; be = '0; we_seen = 1'b0; err = 1'bx; rd = 'x; busy = 1'b0;
    while (!got_done && cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
      LSU_REQ = 1'b0;
      dmem.DMEM_RVALID = (hs_cyc >= 0) && (cyc == hs_cyc + 1 + v.rv_dly);
      if (dmem.DMEM_VALID) begin
        if (vcnt == 0) begin
          a = dmem.DMEM_ADDR; be = dmem.DMEM_BE; wd = dmem.DMEM_WDATA; we_seen = dmem.DMEM_WE;
        end
        dmem.DMEM_READY = (vcnt == v.rdy_dly);
        if (vcnt == v.rdy_dly) hs_cyc = cyc;
        vcnt++;
      end else begin
        dmem.DMEM_READY = 1'b0;
      end
      if (LSU_DONE) begin
        got_done = 1'b1; lat = cyc; err = LSU_ERR; rd = LSU_RDATA; busy = LSU_BUSY;
      end
    end
    dmem.DMEM_READY = 1'b0;
    dmem.DMEM_RVALID = 1'b0;
    tag = $sformatf("v%0d", idx);
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " err"}, {31'h0, err}, {31'h0, v.exp_err});
    chk({tag, " rdata"}, rd, v.exp_rdata);
    chk({tag, " busy@done"}, {31'h0, busy}, 32'h1);
    if (v.exp_req) begin
      chk({tag, " dmem_addr"}, a, v.exp_addr);
      chk({tag, " dmem_be"}, {28'h0, be}, {28'h0, v.exp_be});
      chk({tag, " dmem_wdata"}, wd, v.exp_wdata);
      chk({tag, " dmem_we"}, {31'h0, we_seen}, {31'h0, v.we});
    end else begin
      chk({tag, " no_request"}, 32'(vcnt), 32'h0);
    end
  endtask

  vec_t vecs[11];

  initial begin
    int          cyc, vcnt, done_at, done_cnt;
    logic        err, vd;
    logic [31:0] rd;

    RST_N = 1'b0; LSU_REQ = 1'b0; LSU_WE = 1'b0; LSU_SIZE = 2'd0; LSU_UNSIGNED = 1'b0;
    LSU_ADDR = '0; LSU_WDATA = '0;
    dmem.DMEM_READY = 1'b0; dmem.DMEM_RVALID = 1'b0; dmem.DMEM_RDATA = '0;

    vecs[0]  = mk(1, 2'd0, 0, 32'h103, 32'h000000A5, 32'h0, 0, 0,
                  1, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0, 0, 2);
    vecs[1]  = mk(1, 2'd0, 0, 32'h000, 32'h12345677, 32'h0, 0, 0,
                  1, 32'h000, 4'b0001, 32'h77777777, 32'h0, 0, 2);
    vecs[2]  = mk(1, 2'd1, 0, 32'h006, 32'hDEADBEEF, 32'h0, 0, 0,
                  1, 32'h004, 4'b1100, 32'hBEEFBEEF, 32'h0, 0, 2);
    vecs[3]  = mk(1, 2'd2, 0, 32'h010, 32'hCAFEF00D, 32'h0, 1, 0,
                  1, 32'h010, 4'b1111, 32'hCAFEF00D, 32'h0, 0, 3);
    vecs[4]  = mk(0, 2'd0, 0, 32'h102, 32'h0, 32'h0080FF00, 0, 0,
                  1, 32'h100, 4'hF, 32'h0, 32'hFFFFFF80, 0, 3);
    vecs[5]  = mk(0, 2'd0, 1, 32'h102, 32'h0, 32'h0080FF00, 0, 0,
                  1, 32'h100, 4'hF, 32'h0, 32'h00000080, 0, 3);
    vecs[6]  = mk(0, 2'd1, 0, 32'h202, 32'h0, 32'h80011234, 3, 0,
                  1, 32'h200, 4'hF, 32'h0, 32'hFFFF8001, 0, 6);
    vecs[7]  = mk(0, 2'd1, 1, 32'h300, 32'h0, 32'h1234F00D, 0, 2,
                  1, 32'h300, 4'hF, 32'h0, 32'h0000F00D, 0, 5);
    vecs[8]  = mk(0, 2'd1, 0, 32'h300, 32'h0, 32'h1234F00D, 0, 0,
                  1, 32'h300, 4'hF, 32'h0, 32'hFFFFF00D, 0, 3);
    vecs[9]  = mk(0, 2'd0, 0, 32'h101, 32'h0, 32'h00007F00, 0, 0,
                  1, 32'h100, 4'hF, 32'h0, 32'h0000007F, 0, 3);
`ifdef CORE_LSU_MISALIGN_TRAP_EN
    vecs[10] = mk(0, 2'd2, 0, 32'h201, 32'h0, 32'h12345678, 0, 0,
                  0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 1);
`else
    vecs[10] = mk(0, 2'd2, 0, 32'h201, 32'h0, 32'h12345678, 0, 0,
                  1, 32'h200, 4'hF, 32'h0, 32'h12345678, 0, 3);
`endif

    // Reset state.
    repeat (3) @(posedge CLK);
    #1;
    chk("reset core outs", {29'h0, LSU_BUSY, LSU_DONE, LSU_ERR}, 32'h0);
    chk("reset rdata", LSU_RDATA, 32'h0);
    chk("reset dmem ctl", {26'h0, dmem.DMEM_VALID, dmem.DMEM_WE, dmem.DMEM_BE}, 32'h0);
    chk("reset dmem addr", dmem.DMEM_ADDR, 32'h0);
    RST_N = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Reset asserted while waiting for load data.
    @(posedge CLK); #1;
    LSU_REQ = 1'b1; LSU_WE = 1'b0; LSU_SIZE = 2'd2; LSU_UNSIGNED = 1'b0;
    LSU_ADDR = 32'h500; dmem.DMEM_RDATA = 32'h55AA55AA;
    @(posedge CLK); #1;
    LSU_REQ = 1'b0;
    chk("rst seq valid", {31'h0, dmem.DMEM_VALID}, 32'h1);
    dmem.DMEM_READY = 1'b1;
    @(posedge CLK); #1;
    dmem.DMEM_READY = 1'b0;
    chk("rst seq busy in resp", {31'h0, LSU_BUSY}, 32'h1);
    RST_N = 1'b0;
    @(posedge CLK); #1;
    chk("rst mid core outs", {29'h0, LSU_BUSY, LSU_DONE, LSU_ERR}, 32'h0);
    chk("rst mid rdata", LSU_RDATA, 32'h0);
    chk("rst mid dmem ctl", {26'h0, dmem.DMEM_VALID, dmem.DMEM_WE, dmem.DMEM_BE}, 32'h0);
    chk("rst mid dmem addr", dmem.DMEM_ADDR, 32'h0);
    RST_N = 1'b1;
    dmem.DMEM_RVALID = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK); #1;
      if (c == 2) dmem.DMEM_RVALID = 1'b0;
      if (LSU_DONE || LSU_BUSY) done_cnt++;
    end
    chk("stale rvalid ignored", 32'(done_cnt), 32'h0);

    // Memory never ready: abort after 8 cycles; a request while busy is ignored.
    @(posedge CLK); #1;
    LSU_REQ = 1'b1; LSU_WE = 1'b0; LSU_SIZE = 2'd2; LSU_ADDR = 32'h400;
    cyc = 0; vcnt = 0; done_at = -1; done_cnt = 0; err = 1'b0; rd = 'x; vd = 1'bx;
    while (cyc < 20) begin
      @(posedge CLK); #1;
      cyc++;
      LSU_REQ = (cyc == 3);
      LSU_WE  = (cyc == 3);
      if (dmem.DMEM_VALID) vcnt++;
      if (LSU_DONE) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = cyc; err = LSU_ERR; rd = LSU_RDATA; vd = dmem.DMEM_VALID;
        end
      end
    end
    chk("timeout done cycle", 32'(done_at), 32'd9);
    chk("timeout valid cycles", 32'(vcnt), 32'd8);
    chk("timeout err", {31'h0, err}, 32'h1);
    chk("timeout rdata", rd, 32'h0);
    chk("timeout valid dropped", {31'h0, vd}, 32'h0);
    chk("busy req ignored", 32'(done_cnt), 32'h1);
    chk("idle after timeout", {30'h0, LSU_BUSY, dmem.DMEM_VALID}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_lsu.md
# core_lsu

Load/store unit between the multi-cycle core's MEMORY stage and the data memory port. Converts a single core request (byte/half/word, signed/unsigned, load/store) into one word-aligned memory transaction with byte enables and replicated write data, waits on a valid/ready request channel and an rvalid response channel, then returns lane-extracted, sign/zero-extended load data with a one-cycle done pulse. The core holds in MEMORY while LSU_BUSY is high.

## Interface
- TIMEOUT_CYC, 1023: cycles spent in REQ+RESP before abort; 0 disables timeout.
- CLK  in  1  clock, all logic on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- LSU_REQ  in  1  start pulse; sampled only in IDLE.
- LSU_WE  in  1  1 = store, 0 = load.
- LSU_SIZE  in  2  0 byte, 1 half, 2 word, 3 reserved.
- LSU_UNSIGNED  in  1  zero-extend load (LBU/LHU).
- LSU_ADDR  in  32  byte address.
- LSU_WDATA  in  32  store data, unreplicated (rs2).
- LSU_BUSY  out  1  high from cycle after accepted REQ until DONE cycle inclusive.
- LSU_DONE  out  1  one-cycle completion pulse.
- LSU_ERR  out  1  valid with LSU_DONE: misaligned/illegal (macro) or timeout.
- LSU_RDATA  out  32  extended load data, valid with LSU_DONE; 0 for stores/errors.
- DMEM_VALID  out  1  request valid; held until DMEM_READY.
- DMEM_READY  in  1  memory accepts request.
- DMEM_ADDR  out  32  LSU_ADDR with [1:0] forced 0.
- DMEM_WE  out  1  store request.
- DMEM_BE  out  4  byte enables (stores; 4'hF for loads).
- DMEM_WDATA  out  32  lane-replicated store data.
- DMEM_RVALID  in  1  load data valid.
- DMEM_RDATA  in  32  load word.

## Operation
- States: IDLE, REQ, RESP, DONE. All outputs reset to 0, state to IDLE.
- IDLE: on LSU_REQ register addr/size/we/unsigned/wdata; go REQ (or DONE with ERR, see Configuration).
- REQ: DMEM_VALID=1, DMEM_* stable. On VALID&READY: store -> DONE; load -> RESP.
- RESP: wait DMEM_RVALID; capture formatted data; -> DONE.
- DONE: LSU_DONE=1 for one cycle; -> IDLE. LSU_RDATA held until next DONE.
- Store lanes: byte BE=1<<addr[1:0], WDATA={4{wdata[7:0]}}; half BE=4'b0011<<(2*addr[1]), WDATA={2{wdata[15:0]}}; word BE=4'hF.
- Load extract: byte = RDATA[8*addr[1:0]+:8]; half = RDATA[16*addr[1]+:16]; extend sign bit unless LSU_UNSIGNED; word unchanged.
- Without macro: half ignores addr[0]; word ignores addr[1:0]; size 3 treated as word.
- Timeout: counter clears on REQ entry, counts in REQ and RESP; at TIMEOUT_CYC -> DONE with ERR=1, RDATA=0, DMEM_VALID dropped.
- LSU_REQ while BUSY ignored. DMEM_RVALID outside RESP ignored. DMEM_READY outside REQ ignored.
- Reset mid-transaction: immediate return to IDLE, DMEM_VALID low next edge; memory tolerates abandoned request.

## Timing
- REQ sampled cycle N; DMEM_VALID high N+1.
- Store, READY at N+1: DONE at N+2 (min latency 2).
- Load, READY at N+1, RVALID at N+2 (earliest allowed): DONE + RDATA at N+3 (min latency 3).
- Each READY stall / RVALID delay cycle adds one cycle.
- Error (macro) detected in IDLE: DONE+ERR at N+1, no DMEM_VALID.
- Next LSU_REQ accepted in cycle after DONE.

## Configuration
- CORE_LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1, word with addr[1:0]!=0, or size 3 -> no memory request; DONE+ERR at N+1, RDATA=0.
- Undefined: no misalign check; address low bits masked as above; ERR only from timeout.

## Structure
- Package core_lsu_pkg: size encodings (SZ_B/SZ_H/SZ_W), state encoding, be_gen and load_extend functions.
- Sub-module core_lsu_align: combinational lane steering (BE, replicated WDATA, load extract/extend); FSM, counter and registers in core_lsu.

## Test plan
- SB addr 0x103, wdata 0x000000A5, READY=1 -> DMEM_ADDR 0x100, BE 4'b1000, WDATA 0xA5A5A5A5, DONE at N+2, ERR 0.
- LB addr 0x102, RDATA 0x0080FF00 at RESP -> RDATA 0xFFFFFF80; same with LBU -> 0x00000080; DONE at N+3.
- LH addr 0x202, RDATA 0x8001_1234, READY low 3 cycles -> VALID held, RDATA 0xFFFF8001, DONE at N+6.
- LW addr 0x201 with macro -> DONE+ERR at N+1, no DMEM_VALID; without macro -> DMEM_ADDR 0x200 normal load.
- TIMEOUT_CYC=8, READY never -> DONE+ERR after 8 REQ cycles, RDATA 0; second REQ during BUSY ignored.
- RST_N low during RESP -> next edge state IDLE, all outputs 0; later RVALID ignored.
